camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture_pkg.sv | 36 +++
 rtl/camera_capture_pixel_pack.sv | 75 +++++++
 rtl/camera_capture.sv | 160 ++++++++++++++++
 tb/tb_camera_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// Shared definitions for the camera capture path and the VGA display path.
// Holds the capture FSM state type, default frame geometry and the RGB565
// field positions used to pull colour channels out of a 16-bit pixel.
package camera_capture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } cap_state_e;

    localparam int DEFAULT_H_ACTIVE = 640;
    localparam int DEFAULT_V_ACTIVE = 480;

    localparam int INTENSITY_W = 4;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    function automatic logic [4:0] rgb565_red(input logic [15:0] pix);
        return pix[RGB565_R_MSB:RGB565_R_LSB];
    endfunction

    function automatic logic [5:0] rgb565_green(input logic [15:0] pix);
        return pix[RGB565_G_MSB:RGB565_G_LSB];
    endfunction

    function automatic logic [4:0] rgb565_blue(input logic [15:0] pix);
        return pix[RGB565_B_MSB:RGB565_B_LSB];
    endfunction

endpackage

// File: rtl/camera_capture_pixel_pack.sv
// cam_pixel_pack: pairs camera bytes into RGB565 pixels and reduces each
// pixel to a 4-bit intensity. The first byte of a pair is held; the second
// byte is combined with it in the same cycle it arrives.
// Build option: CAM_GRAY_EN selects a weighted gray (R + 2G + B) / 4;
// without it the intensity is simply the top four green bits.
module cam_pixel_pack
    import camera_capture_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample,
    input  logic                   clear,
    input  logic [7:0]             byte_in,
    output logic                   pix_strobe,
    output logic [INTENSITY_W-1:0] pix_intensity
);

    logic       phase_q, phase_d;
    logic [7:0] hi_byte_q, hi_byte_d;
    logic [15:0] pixel;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       unused_bits;

    // Byte phase tracking: first byte is stored, second byte completes a pixel.
    always_comb begin
        phase_d    = phase_q;
        hi_byte_d  = hi_byte_q;
        pix_strobe = 1'b0;
        if (clear) begin
            phase_d = 1'b0;
        end else if (sample) begin
            if (!phase_q) begin
                hi_byte_d = byte_in;
                phase_d   = 1'b1;
            end else begin
                phase_d    = 1'b0;
                pix_strobe = 1'b1;
            end
        end
    end

    // Phase and held first byte registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            hi_byte_q <= 8'd0;
        end else begin
            phase_q   <= phase_d;
            hi_byte_q <= hi_byte_d;
        end
    end

    assign pixel = {hi_byte_q, byte_in};
    assign red   = rgb565_red(pixel);
    assign green = rgb565_green(pixel);
    assign blue  = rgb565_blue(pixel);

`ifdef CAM_GRAY_EN
    logic [5:0] gray_sum;

    // Weighted gray sum; worst case 15 + 30 + 15 = 60 fits in six bits.
    always_comb begin
        gray_sum = {2'b00, red[4:1]} + {1'b0, green[5:2], 1'b0} + {2'b00, blue[4:1]};
    end

    assign pix_intensity = gray_sum[5:2];
    assign unused_bits   = ^{red[0], green[1:0], blue[0]};
`else
    assign pix_intensity = green[5:2];
    assign unused_bits   = ^{red, green[1:0], blue};
`endif

endmodule

// File: rtl/camera_capture.sv
// camera_capture: receives an RGB565 byte stream from a camera (VSYNC/HREF
// framing) and writes one 4-bit intensity per pixel into a frame buffer.
// Holds the capture FSM, the x/y counters and the incremental write address;
// byte pairing and intensity conversion live in cam_pixel_pack.
// Build option: CAM_GRAY_EN (see cam_pixel_pack) changes only wr_data.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
    parameter int ADDR_W   = 19
) (
    input  logic                   pixel_clk,
    input  logic                   rst_n,
    input  logic                   capture_en,
    input  logic                   cam_vsync,
    input  logic                   cam_href,
    input  logic [7:0]             cam_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [INTENSITY_W-1:0] wr_data,
    output logic                   frame_done,
    output logic                   overflow
);

    // Counters carry one extra value so "past the edge" is representable.
    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_LIMIT   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIMIT   = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    cap_state_e state_q, state_d;

    logic vsync_q, href_q;
    logic vsync_rise, vsync_fall, href_fall;
    logic in_capture, sof, sample, pack_clear;

    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic [ADDR_W-1:0]      line_base_q, line_base_d;
    logic                   line_pix_q, line_pix_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [INTENSITY_W-1:0] wr_data_q, wr_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;

    logic                   pix_strobe;
    logic [INTENSITY_W-1:0] pix_intensity;

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign vsync_fall = ~cam_vsync & vsync_q;
    assign href_fall  = ~cam_href & href_q;

    assign in_capture = (state_q == CAPTURE);
    assign sof        = (state_q == WAIT_SOF) && vsync_fall;
    // A VSYNC rise aborts the line, so the byte present on that edge is dropped.
    assign sample     = in_capture && cam_href && !vsync_rise;
    assign pack_clear = sof || (in_capture && href_fall);

    cam_pixel_pack u_pack (
        .clk           (pixel_clk),
        .rst_n         (rst_n),
        .sample        (sample),
        .clear         (pack_clear),
        .byte_in       (cam_data),
        .pix_strobe    (pix_strobe),
        .pix_intensity (pix_intensity)
    );

    // Next-state logic for the capture FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (capture_en) state_d = WAIT_SOF;
            WAIT_SOF: if (vsync_fall) state_d = CAPTURE;
            CAPTURE:  if (vsync_rise) state_d = capture_en ? WAIT_SOF : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Counters, address generation, write strobe, frame_done and overflow.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        line_base_d  = line_base_q;
        line_pix_d   = line_pix_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        if (sof) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
            line_pix_d  = 1'b0;
        end else if (in_capture) begin
            if (vsync_rise) begin
                frame_done_d = (x_q != '0) || (y_q != '0);
            end else if (href_fall) begin
                x_d        = '0;
                line_pix_d = 1'b0;
                if (line_pix_q && (y_q < Y_LIMIT)) begin
                    y_d         = y_q + 1'b1;
                    line_base_d = line_base_q + LINE_STEP;
                end
            end else if (pix_strobe) begin
                line_pix_d = 1'b1;
                if ((x_q < X_LIMIT) && (y_q < Y_LIMIT)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = line_base_q + ADDR_W'(x_q);
                    wr_data_d = pix_intensity;
                    x_d       = x_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // State, edge-detect and datapath registers with synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            line_base_q  <= '0;
            line_pix_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= cam_vsync;
            href_q       <= cam_href;
            x_q          <= x_d;
            y_q          <= y_d;
            line_base_q  <= line_base_d;
            line_pix_q   <= line_pix_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_camera_capture.sv
// Testbench for camera_capture on a 4x2 frame. Expected writes are queued
// as pixels are driven; a monitor pops and compares on every wr_en.
module tb_camera_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 19;

`ifdef CAM_GRAY_EN
    localparam logic [3:0] RED_I     = 4'd3;
    localparam logic [3:0] GREEN_I   = 4'd7;
    localparam logic [3:0] BLUE_I    = 4'd3;
    localparam logic [3:0] DARKRED_I = 4'd2;
    localparam logic [3:0] MIX_I     = 4'd4;
`else
    localparam logic [3:0] RED_I     = 4'd0;
    localparam logic [3:0] GREEN_I   = 4'd15;
    localparam logic [3:0] BLUE_I    = 4'd0;
    localparam logic [3:0] DARKRED_I = 4'd0;
    localparam logic [3:0] MIX_I     = 4'd4;
`endif

    logic          pixel_clk  = 1'b0;
    logic          rst_n      = 1'b0;
    logic          capture_en = 1'b0;
    logic          cam_vsync  = 1'b0;
    logic          cam_href   = 1'b0;
    logic [7:0]    cam_data   = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          frame_done;
    logic          overflow;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    data;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int checks  = 0;
    int passed  = 0;
    int fd_seen = 0;

    camera_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        else
            passed++;
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge pixel_clk) begin : monitor
        wr_exp_t e;
        if (rst_n) begin
            if (frame_done) fd_seen++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
                    checkOutput("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    // Drive one pixel (two bytes) with HREF high, queueing the write if expected.
    task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo, input bit expect_wr,
                                 input int addr, input logic [3:0] data);
        wr_exp_t e;
        if (expect_wr) begin
            e.addr = AW'(addr);
            e.data = data;
            exp_q.push_back(e);
        end
        cam_href = 1'b1;
        cam_data = hi;
        tick(1);
        cam_data = lo;
        tick(1);
    endtask

    task automatic endLine();
        cam_href = 1'b0;
        cam_data = 8'd0;
        tick(2);
    endtask

    task automatic startFrame();
        cam_vsync = 1'b1;
        tick(2);
        cam_vsync = 1'b0;
        tick(2);
    endtask

    task automatic endFrame();
        cam_vsync = 1'b1;
        tick(3);
    endtask

    initial begin
        // Reset with busy inputs
        rst_n      = 1'b0;
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cam_vsync = i[0];
            cam_href  = ~i[1];
            cam_data  = 8'(i * 37);
            tick(1);
        end
        checkOutput("reset_wr_en", 32'(wr_en), 0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 0);
        checkOutput("reset_wr_data", 32'(wr_data), 0);
        checkOutput("reset_frame_done", 32'(frame_done), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);

        // Release with VSYNC held low: no capture may start
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cam_href = ~cam_href;
            cam_data = 8'hFF;
            tick(1);
            checkOutput("post_reset_wr_en", 32'(wr_en), 0);
        end
        cam_href = 1'b0;
        tick(2);

        // Full 4x2 frame of white pixels
        startFrame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++)
                applyStimulus(8'hFF, 8'hFF, 1'b1, y * H + x, 4'd15);
            endLine();
        end
        endFrame();
        checkOutput("frameA_frame_done_count", 32'(fd_seen), 1);
        checkOutput("frameA_pending_writes", 32'(exp_q.size()), 0);
        checkOutput("frameA_overflow", 32'(overflow), 0);

        // Colour conversion, line overflow and dangling byte
        startFrame();
        applyStimulus(8'hF8, 8'h00, 1'b1, 0, RED_I);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1, 4'd15);
        applyStimulus(8'h07, 8'hE0, 1'b1, 2, GREEN_I);
        applyStimulus(8'h00, 8'h1F, 1'b1, 3, BLUE_I);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 4'd0);
        cam_data = 8'hAA;
        tick(1);
        endLine();
        checkOutput("frameB_overflow", 32'(overflow), 1);
        applyStimulus(8'h12, 8'h34, 1'b1, 4, MIX_I);
        applyStimulus(8'h80, 8'h00, 1'b1, 5, DARKRED_I);
        endLine();
        endFrame();
        checkOutput("frameB_frame_done_count", 32'(fd_seen), 2);
        checkOutput("frameB_pending_writes", 32'(exp_q.size()), 0);

        // VSYNC rises mid-line at x=2 with a half pixel pending
        startFrame();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 4'd15);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1, 4'd15);
        cam_data = 8'hFF;
        tick(1);
        cam_vsync = 1'b1;
        tick(1);
        cam_data = 8'h00;
        tick(3);
        cam_href = 1'b0;
        tick(2);
        checkOutput("frameC_frame_done_count", 32'(fd_seen), 3);
        checkOutput("frameC_pending_writes", 32'(exp_q.size()), 0);

        // Next frame restarts at address 0 with a clean byte phase
        startFrame();
        applyStimulus(8'h12, 8'h34, 1'b1, 0, MIX_I);
        endLine();
        endFrame();
        checkOutput("frameD_frame_done_count", 32'(fd_seen), 4);
        checkOutput("frameD_pending_writes", 32'(exp_q.size()), 0);

        // capture_en dropped during line 0: frame completes, then idle
        startFrame();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 4'd15);
        capture_en = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1, 4'd15);
        endLine();
        applyStimulus(8'h12, 8'h34, 1'b1, 4, MIX_I);
        endLine();
        endFrame();
        checkOutput("frameE_frame_done_count", 32'(fd_seen), 5);
        startFrame();
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 4'd0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 4'd0);
        endLine();
        endFrame();
        checkOutput("frameF_frame_done_count", 32'(fd_seen), 5);
        checkOutput("frameF_pending_writes", 32'(exp_q.size()), 0);
        checkOutput("sticky_overflow", 32'(overflow), 1);

        // Reset mid-frame drops the frame and clears overflow
        capture_en = 1'b1;
        tick(1);
        startFrame();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 4'd15);
        cam_data = 8'hFF;
        tick(1);
        rst_n = 1'b0;
        tick(2);
        checkOutput("midreset_overflow", 32'(overflow), 0);
        checkOutput("midreset_wr_en", 32'(wr_en), 0);
        rst_n = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 4'd0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 4'd0);
        endLine();
        startFrame();
        checkOutput("midreset_frame_done_count", 32'(fd_seen), 5);
        applyStimulus(8'h07, 8'hE0, 1'b1, 0, GREEN_I);
        endLine();
        endFrame();
        checkOutput("frameG_frame_done_count", 32'(fd_seen), 6);
        checkOutput("frameG_pending_writes", 32'(exp_q.size()), 0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
